id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline register plus load-use/branch hazard stall FSM. Captures decoded ID fields
//  and drives the EX-side fields the forwarding logic consumes (ex_rs, ex_rt, ex_dest, ctrl bits).
//  Detects hazards that forwarding cannot cover, holds PC/IF-ID and injects bubbles into EX.
// PARAMETERS
//  WORD_W          32  data/PC/immediate width
//  REG_W           5   register index width
//  LDBR_BUBBLES    2   bubbles for a branch in ID that depends on a load in EX (legal range 1..3)
// PORTS
//  CLK          in   1       clock, rising edge
//  nRST         in   1       asynchronous active-low reset
//  en           in   1       pipeline advance (ihit/dhit qualified); no state changes when 0
//  flush        in   1       branch/jump taken: squash the ID instruction
//  id_valid     in   1       ID holds a real instruction
//  id_rs/id_rt/id_rd in REG_W  source/dest indices
//  id_RegDst    in   1       1: dest=rd (R-type), 0: dest=rt
//  id_regWr, id_memRead, id_memWr, id_isBranch, id_usesRt  in 1  decoded control
//  id_aluop     in   4       ALU op
//  id_rdat1/2, id_imm, id_pc  in WORD_W  operands, sign-extended imm, PC+4
//  ex_valid     out  1       EX holds a real instruction
//  ex_rs/ex_rt/ex_dest out REG_W  registered indices; ex_dest = RegDst ? rd : rt, 0 if !regWr
//  ex_RegDst, ex_regWr, ex_memRead, ex_memWr  out 1  registered control
//  ex_aluop     out  4;  ex_rdat1/2, ex_imm, ex_pc  out WORD_W
//  stall_id     out  1       hold PC and IF/ID (combinational from state + hazard detect)
//  stall_cnt, bubble_cnt  out 32  performance counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all ex_* = 0, ex_valid = 0, state RUN, cnt = 0, counters = 0; stall_id = 0.
//  Hazard detect (combinational, RUN only; all terms AND id_valid, src != 0):
//   LU: ex_valid & ex_memRead & (ex_rt==id_rs | id_usesRt & ex_rt==id_rt) -> need 1 bubble
//   BA: id_isBranch & ex_valid & ex_regWr & !ex_memRead & ex_dest matches rs/rt -> 1 bubble
//   BL: id_isBranch & LU condition -> LDBR_BUBBLES bubbles (BL wins over LU)
//  FSM states RUN, STALL; 2-bit cnt = bubbles remaining.
//   RUN, no hazard, en: EX <= ID fields, ex_valid <= id_valid & !flush.
//   RUN, hazard: stall_id=1; on en: EX <= bubble (all ctrl 0, ex_valid 0, indices 0),
//     cnt <= need-1; go STALL if need>1 else stay RUN (re-evaluates next cycle).
//   STALL: stall_id=1; on en: EX <= bubble, cnt--; at cnt==0 after decrement -> RUN.
//  flush (any state, with en): EX <= bubble, state RUN, cnt 0, stall_id=0 that cycle.
//  en=0: EX registers, state, cnt, counters hold; stall_id still reflects hazard.
//  Bubble zeroes regWr/memWr/memRead so no downstream side effect; data fields may hold.
//  Latency: 1 cycle ID->EX; stall_id asserted same cycle as detection.
//  Reset mid-stall: immediate return to RUN with bubble in EX.
// CONFIGURATION
//  STALL_COUNT_EN defined: stall_cnt increments each en cycle with stall_id=1; bubble_cnt
//   increments each en cycle a bubble (hazard or flush) enters EX; both wrap at 2^32.
//  Not defined: counter logic omitted; stall_cnt and bubble_cnt tied to 0.
// TESTING
//  lw $2 in EX; add $3,$2,$4 in ID, en=1 -> stall_id=1 one cycle, one bubble, add enters EX next.
//  lw $5 in EX; beq $5,$0 in ID -> stall_id=1 for 2 en cycles, 2 bubbles, then beq proceeds.
//  add $6 in EX; beq $6,$7 in ID -> exactly 1 bubble; sw $6 rt-only use w/ id_usesRt=0 -> none.
//  flush during STALL cnt=1 -> EX bubble, state RUN, stall_id=0 same cycle.
//  en=0 for 3 cycles during STALL -> cnt/ex_* unchanged; resumes with remaining bubbles.
//  nRST low mid-operation -> all outputs 0 asynchronously; STALL_COUNT_EN: after 1st test
//   stall_cnt=1, bubble_cnt=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID->EX pipeline register with load-use/branch hazard stall FSM
// Optional feature: define STALL_COUNT_EN to build the stall/bubble performance counters.
module id_ex_stage #(
  parameter int WORD_W       = 32,
  parameter int REG_W        = 5,
  parameter int LDBR_BUBBLES = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_RegDst,
  input  logic              id_regWr,
  input  logic              id_memRead,
  input  logic              id_memWr,
  input  logic              id_isBranch,
  input  logic              id_usesRt,
  input  logic [3:0]        id_aluop,
  input  logic [WORD_W-1:0] id_rdat1,
  input  logic [WORD_W-1:0] id_rdat2,
  input  logic [WORD_W-1:0] id_imm,
  input  logic [WORD_W-1:0] id_pc,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_dest,
  output logic              ex_RegDst,
  output logic              ex_regWr,
  output logic              ex_memRead,
  output logic              ex_memWr,
  output logic [3:0]        ex_aluop,
  output logic [WORD_W-1:0] ex_rdat1,
  output logic [WORD_W-1:0] ex_rdat2,
  output logic [WORD_W-1:0] ex_imm,
  output logic [WORD_W-1:0] ex_pc,
  output logic              stall_id,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;
  localparam logic [1:0] LDBR_N   = 2'(LDBR_BUBBLES);

  logic [0:0] state;
  logic [1:0] cnt;
  logic       rs_nz, rt_nz, lu_hit, ba_hit, bl_hit, hazard, bubble;
  logic [1:0] need;

  assign rs_nz  = (id_rs != '0);
  assign rt_nz  = (id_rt != '0);
  assign lu_hit = id_valid & ex_valid & ex_memRead &
                  ((rs_nz & (ex_rt == id_rs)) | (id_usesRt & rt_nz & (ex_rt == id_rt)));
  assign ba_hit = id_valid & id_isBranch & ex_valid & ex_regWr & !ex_memRead &
                  ((rs_nz & (ex_dest == id_rs)) | (rt_nz & (ex_dest == id_rt)));
  assign bl_hit = id_isBranch & lu_hit;
  assign hazard = (state == ST_RUN) & (lu_hit | ba_hit);
  assign need   = bl_hit ? LDBR_N : 2'd1;

  // A taken branch squashes ID, so there is nothing left to hold.
  assign stall_id = ((state == ST_STALL) | hazard) & !flush;
  assign bubble   = flush | stall_id;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_valid   <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_dest    <= '0;
      ex_RegDst  <= 1'b0;
      ex_regWr   <= 1'b0;
      ex_memRead <= 1'b0;
      ex_memWr   <= 1'b0;
      ex_aluop   <= '0;
      ex_rdat1   <= '0;
      ex_rdat2   <= '0;
      ex_imm     <= '0;
      ex_pc      <= '0;
    end else if (en) begin
      if (bubble) begin
        ex_valid   <= 1'b0;
        ex_rs      <= '0;
        ex_rt      <= '0;
        ex_dest    <= '0;
        ex_RegDst  <= 1'b0;
        ex_regWr   <= 1'b0;
        ex_memRead <= 1'b0;
        ex_memWr   <= 1'b0;
        ex_aluop   <= '0;
      end else begin
        ex_valid   <= id_valid;
        ex_rs      <= id_rs;
        ex_rt      <= id_rt;
        ex_dest    <= id_regWr ? (id_RegDst ? id_rd : id_rt) : '0;
        ex_RegDst  <= id_RegDst;
        ex_regWr   <= id_regWr;
        ex_memRead <= id_memRead;
        ex_memWr   <= id_memWr;
        ex_aluop   <= id_aluop;
        ex_rdat1   <= id_rdat1;
        ex_rdat2   <= id_rdat2;
        ex_imm     <= id_imm;
        ex_pc      <= id_pc;
      end
    end
  end

  // cnt counts bubbles still owed after the one entering EX this cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ST_RUN;
      cnt   <= 2'd0;
    end else if (en) begin
      if (flush) begin
        state <= ST_RUN;
        cnt   <= 2'd0;
      end else if (state == ST_STALL) begin
        cnt <= cnt - 2'd1;
        if (cnt == 2'd1) state <= ST_RUN;
      end else if (hazard) begin
        cnt   <= need - 2'd1;
        state <= (need > 2'd1) ? ST_STALL : ST_RUN;
      end
    end
  end

`ifdef STALL_COUNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (en) begin
      if (stall_id) stall_cnt  <= stall_cnt + 32'd1;
      if (bubble)   bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage hazard stalls, flush, hold and reset
module tb_id_ex_stage;

  typedef struct packed {
    logic [4:0]  rs, rt, dest;
    logic        rdst, rw, mr, mw;
    logic [3:0]  aluop;
    logic [31:0] r1, r2, imm, pc;
  } rec_t;

  logic        CLK, nRST, en, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_RegDst, id_regWr, id_memRead, id_memWr, id_isBranch, id_usesRt;
  logic [3:0]  id_aluop;
  logic [31:0] id_rdat1, id_rdat2, id_imm, id_pc;
  logic        ex_valid, ex_RegDst, ex_regWr, ex_memRead, ex_memWr, stall_id;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [3:0]  ex_aluop;
  logic [31:0] ex_rdat1, ex_rdat2, ex_imm, ex_pc, stall_cnt, bubble_cnt;

  int   n_chk = 0;
  int   n_fail = 0;
  rec_t exp_q[$];

  id_ex_stage dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_RegDst(id_RegDst),
    .id_regWr(id_regWr), .id_memRead(id_memRead), .id_memWr(id_memWr),
    .id_isBranch(id_isBranch), .id_usesRt(id_usesRt), .id_aluop(id_aluop),
    .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm), .id_pc(id_pc),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_RegDst(ex_RegDst), .ex_regWr(ex_regWr), .ex_memRead(ex_memRead),
    .ex_memWr(ex_memWr), .ex_aluop(ex_aluop), .ex_rdat1(ex_rdat1),
    .ex_rdat2(ex_rdat2), .ex_imm(ex_imm), .ex_pc(ex_pc), .stall_id(stall_id),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, rt, rd, input logic rdst, rw, mr,
                        mw, br, ur, input logic [3:0] aluop, input logic [31:0] pc);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_RegDst = rdst; id_regWr = rw;
    id_memRead = mr; id_memWr = mw; id_isBranch = br; id_usesRt = ur; id_aluop = aluop;
    id_pc = pc; id_rdat1 = 32'hA000_0000 | pc; id_rdat2 = 32'hB000_0000 | pc;
    id_imm = 32'hC000_0000 | pc;
  endtask

  task automatic push(input logic [4:0] rs, rt, dest, input logic rdst, rw, mr, mw,
                      input logic [3:0] aluop, input logic [31:0] pc);
    rec_t r;
    r.rs = rs; r.rt = rt; r.dest = dest; r.rdst = rdst; r.rw = rw; r.mr = mr; r.mw = mw;
    r.aluop = aluop; r.pc = pc; r.r1 = 32'hA000_0000 | pc; r.r2 = 32'hB000_0000 | pc;
    r.imm = 32'hC000_0000 | pc;
    exp_q.push_back(r);
  endtask

  // Called right after a negedge with inputs set: check stall_id, then run one clock.
  task automatic cyc(input logic exp_stall, input string nm);
    #1 chk({nm, "_stall_id"}, stall_id, exp_stall);
    @(negedge CLK);
  endtask

  task automatic chk_bubble(input string nm);
    chk({nm, "_ex_valid"}, ex_valid, 1'b0);
    chk({nm, "_bubble_ctrl"}, {ex_regWr, ex_memRead, ex_memWr}, 3'b000);
  endtask

  // Monitor: each time an instruction advances into EX, pop and compare.
  initial begin
    logic adv;
    rec_t got;
    forever begin
      @(posedge CLK);
      adv = en && nRST;
      #1;
      if (adv && ex_valid) begin
        got = '{ex_rs, ex_rt, ex_dest, ex_RegDst, ex_regWr, ex_memRead, ex_memWr, ex_aluop,
                ex_rdat1, ex_rdat2, ex_imm, ex_pc};
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ex: got %0h expected none", got);
        end else begin
          chk("ex_fields", got, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    nRST = 1'b0; en = 1'b1; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_stall_id", stall_id, 1'b0);
    chk("rst_ex_fields", {ex_rs, ex_rt, ex_dest, ex_regWr, ex_memRead, ex_pc}, '0);
    chk("rst_counters", {stall_cnt, bubble_cnt}, '0);
    @(negedge CLK);
    nRST = 1'b1;

    // load-use: lw $2 then add $3,$2,$4
    set_id(1, 1, 2, 0, 0, 1, 1, 0, 0, 0, 4'h2, 4); push(1, 2, 2, 0, 1, 1, 0, 4'h2, 4);
    cyc(0, "A_lw");
    set_id(1, 2, 4, 3, 1, 1, 0, 0, 0, 1, 4'h1, 8);
    cyc(1, "B_lu");
    chk_bubble("B");
`ifdef STALL_COUNT_EN
    chk("cnt_after_lu", {stall_cnt, bubble_cnt}, {32'd1, 32'd1});
`else
    chk("cnt_tied_zero", {stall_cnt, bubble_cnt}, '0);
`endif
    push(2, 4, 3, 1, 1, 0, 0, 4'h1, 8);
    cyc(0, "C_add_go");

    // branch on load: lw $5 then beq $5,$0 -> two bubbles
    set_id(1, 1, 5, 0, 0, 1, 1, 0, 0, 0, 4'h2, 12); push(1, 5, 5, 0, 1, 1, 0, 4'h2, 12);
    cyc(0, "D_lw");
    set_id(1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 4'h6, 16);
    cyc(1, "E_bl1");
    chk_bubble("E");
    cyc(1, "F_bl2");
    chk_bubble("F");
    push(5, 0, 0, 0, 0, 0, 0, 4'h6, 16);
    cyc(0, "G_beq_go");

    // branch on ALU result: add $6 then beq $6,$7 -> one bubble
    set_id(1, 1, 1, 6, 1, 1, 0, 0, 0, 1, 4'h1, 20); push(1, 1, 6, 1, 1, 0, 0, 4'h1, 20);
    cyc(0, "H_add6");
    set_id(1, 6, 7, 0, 0, 0, 0, 0, 1, 1, 4'h6, 24);
    cyc(1, "I_ba");
    chk_bubble("I");
    push(6, 7, 0, 0, 0, 0, 0, 4'h6, 24);
    cyc(0, "J_ba_one");

    // lw $6 then sw with rt=$6 but usesRt=0 -> no hazard
    set_id(1, 1, 6, 0, 0, 1, 1, 0, 0, 0, 4'h2, 28); push(1, 6, 6, 0, 1, 1, 0, 4'h2, 28);
    cyc(0, "K_lw6");
    set_id(1, 1, 6, 0, 0, 0, 0, 1, 0, 0, 4'h3, 32); push(1, 6, 0, 0, 0, 0, 1, 4'h3, 32);
    cyc(0, "L_sw_nouse");

    // flush while STALL with cnt=1
    set_id(1, 1, 5, 0, 0, 1, 1, 0, 0, 0, 4'h2, 36); push(1, 5, 5, 0, 1, 1, 0, 4'h2, 36);
    cyc(0, "M_lw");
    set_id(1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 4'h6, 40);
    cyc(1, "N_bl");
    flush = 1'b1;
    cyc(0, "O_flush");
    flush = 1'b0;
    chk_bubble("O");
    set_id(1, 1, 1, 3, 1, 1, 0, 0, 0, 1, 4'h1, 44); push(1, 1, 3, 1, 1, 0, 0, 4'h1, 44);
    cyc(0, "P_run");

    // en=0 for three cycles inside a stall
    set_id(1, 1, 5, 0, 0, 1, 1, 0, 0, 0, 4'h2, 48); push(1, 5, 5, 0, 1, 1, 0, 4'h2, 48);
    cyc(0, "Q_lw");
    set_id(1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 4'h6, 52);
    cyc(1, "R_bl");
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_bubble("hold");
      cyc(1, "hold");
    end
    en = 1'b1;
    cyc(1, "V_resume");
    chk_bubble("V");
    push(5, 0, 0, 0, 0, 0, 0, 4'h6, 52);
    cyc(0, "W_beq_go");
`ifdef STALL_COUNT_EN
    chk("cnt_total", {stall_cnt, bubble_cnt}, {32'd7, 32'd8});
`else
    chk("cnt_total_zero", {stall_cnt, bubble_cnt}, '0);
`endif

    // asynchronous reset in the middle of a stall
    set_id(1, 1, 5, 0, 0, 1, 1, 0, 0, 0, 4'h2, 56); push(1, 5, 5, 0, 1, 1, 0, 4'h2, 56);
    cyc(0, "X_lw");
    set_id(1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 4'h6, 60);
    cyc(1, "Y_bl");
    #2 nRST = 1'b0;
    #1;
    chk("arst_ex_valid", ex_valid, 1'b0);
    chk("arst_stall_id", stall_id, 1'b0);
    chk("arst_ex_fields", {ex_rs, ex_rt, ex_dest, ex_regWr, ex_memRead, ex_pc}, '0);
    chk("arst_counters", {stall_cnt, bubble_cnt}, '0);
    @(negedge CLK);
    nRST = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, "Z_idle");
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
